// File: rtl/modulator_pkg.sv
// Shared definitions for the time-shared modulator bank: mode codes, FSM states, default width.
package modulator_pkg;

  localparam int BITSIZE_DEF = 16;

  typedef enum logic [1:0] {
    MODE_AM     = 2'b00,
    MODE_RING   = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_MUTE   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    M1   = 2'b01,
    M2   = 2'b10,
    WR   = 2'b11
  } state_e;

endpackage

// File: rtl/modulator_mac.sv
// Registered signed Q1.(BITSIZE-1) multiplier: full product, floor shift, saturate.
// Latency: 1 cycle, operands at t give prod at t+1.
// Backpressure: none, accepts new operands every cycle.
module modulator_mac
  import modulator_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [BITSIZE-1:0] op_a,
  input  logic signed [BITSIZE-1:0] op_b,
  output logic signed [BITSIZE-1:0] prod
);

  localparam logic signed [2*BITSIZE-1:0] PMAX = {{(BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [2*BITSIZE-1:0] PMIN = {{(BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  logic signed [2*BITSIZE-1:0] opa_x;
  logic signed [2*BITSIZE-1:0] opb_x;
  logic signed [2*BITSIZE-1:0] full;
  logic signed [2*BITSIZE-1:0] shifted;
  logic signed [BITSIZE-1:0]   sat;

  assign opa_x   = {{BITSIZE{op_a[BITSIZE-1]}}, op_a};
  assign opb_x   = {{BITSIZE{op_b[BITSIZE-1]}}, op_b};
  assign full    = opa_x * opb_x;
  // Arithmetic shift floors toward minus infinity; only (-1)*(-1) can exceed the range.
  assign shifted = full >>> (BITSIZE - 1);

  always_comb begin
    sat = shifted[BITSIZE-1:0];
    if (shifted > PMAX) begin
      sat = PMAX[BITSIZE-1:0];
    end else if (shifted < PMIN) begin
      sat = PMIN[BITSIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
    end else begin
      prod <= sat;
    end
  end

endmodule

// File: rtl/modulator_bank.sv
// Multi-channel AM/ring/bypass/mute modulator sharing one multiplier across channels.
// Latency: sample at cycle 0 gives out/out_valid at cycle 3*CHANNELS+1.
// Backpressure: none; a sample while busy is dropped and flagged on overrun.
module modulator_bank
  import modulator_pkg::*;
#(
  parameter int BITSIZE  = BITSIZE_DEF,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample,
  input  logic [CHANNELS*BITSIZE-1:0]  in1,
  input  logic [CHANNELS*BITSIZE-1:0]  in2,
  input  logic [CHANNELS*BITSIZE-1:0]  a,
  input  logic [CHANNELS*BITSIZE-1:0]  b,
  input  logic [2*CHANNELS-1:0]        mode,
  output logic [CHANNELS*BITSIZE-1:0]  out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  state_e state, state_nxt;
  logic [CW-1:0] ch;
  logic          accept;
  logic          last_ch;

  logic signed [BITSIZE-1:0] s_in1   [CHANNELS];
  logic signed [BITSIZE-1:0] s_in2   [CHANNELS];
  logic signed [BITSIZE-1:0] s_a     [CHANNELS];
  logic signed [BITSIZE-1:0] s_b     [CHANNELS];
  mode_e                     s_mode  [CHANNELS];
  logic signed [BITSIZE-1:0] staging [CHANNELS];

  logic signed [BITSIZE-1:0] op_a, op_b, prod;
  logic signed [BITSIZE:0]   add_full;
  logic signed [BITSIZE-1:0] add_sat;
  logic signed [BITSIZE-1:0] result;

  assign accept  = (state == IDLE) && sample;
  assign last_ch = (ch == LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = M1;
      M1:      state_nxt = M2;
      M2:      state_nxt = WR;
      WR:      state_nxt = last_ch ? IDLE : M1;
      default: state_nxt = IDLE;
    endcase
  end

  // In M2 the multiplier output holds a*in2, so the AM offset is added here.
  always_comb begin
    add_full = {prod[BITSIZE-1], prod} + {s_b[ch][BITSIZE-1], s_b[ch]};
    add_sat  = add_full[BITSIZE-1:0];
    if (add_full[BITSIZE] != add_full[BITSIZE-1]) begin
      add_sat = add_full[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}}
                                  : {1'b0, {(BITSIZE-1){1'b1}}};
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == M1) begin
      op_a = s_a[ch];
      op_b = s_in2[ch];
    end else if (state == M2) begin
      case (s_mode[ch])
        MODE_AM:   begin op_a = add_sat;   op_b = s_in1[ch]; end
        MODE_RING: begin op_a = s_in2[ch]; op_b = s_in1[ch]; end
        default:   ;
      endcase
    end
  end

  always_comb begin
    case (s_mode[ch])
      MODE_AM, MODE_RING: result = prod;
      MODE_BYPASS:        result = s_in1[ch];
      default:            result = '0;
    endcase
  end

  modulator_mac #(.BITSIZE(BITSIZE)) u_mac (
    .clk   (clk),
    .reset (reset),
    .op_a  (op_a),
    .op_b  (op_b),
    .prod  (prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ch        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        s_in1[k]   <= '0;
        s_in2[k]   <= '0;
        s_a[k]     <= '0;
        s_b[k]     <= '0;
        s_mode[k]  <= MODE_AM;
        staging[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample && busy;
      if (accept) begin
        ch <= '0;
        for (int k = 0; k < CHANNELS; k++) begin
          s_in1[k]  <= in1[k*BITSIZE +: BITSIZE];
          s_in2[k]  <= in2[k*BITSIZE +: BITSIZE];
          s_a[k]    <= a[k*BITSIZE +: BITSIZE];
          s_b[k]    <= b[k*BITSIZE +: BITSIZE];
          s_mode[k] <= mode_e'(mode[2*k +: 2]);
        end
      end
      if (state == WR) begin
        staging[ch] <= result;
        if (last_ch) begin
          // Last channel's result bypasses staging so all channels publish together.
          for (int k = 0; k < CHANNELS; k++) begin
            out[k*BITSIZE +: BITSIZE] <= (CW'(k) == ch) ? result : staging[k];
          end
          out_valid <= 1'b1;
        end else begin
          ch <= ch + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_modulator_bank.sv
// Directed bench for modulator_bank (4 channels, 16 bit) with a queue-based scoreboard.
module tb_modulator_bank;

  localparam int B = 16;
  localparam int C = 4;
  localparam int LAT = 3 * C + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sample = 1'b0;
  logic [C*B-1:0] in1 = '0, in2 = '0, a = '0, b = '0;
  logic [2*C-1:0] mode = '0;
  logic [C*B-1:0] out;
  logic           out_valid, busy, overrun;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [C*B-1:0] exp_q[$];
  int             exp_cyc_q[$];
  int             ovr_q[$];

  modulator_bank #(.BITSIZE(B), .CHANNELS(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample    (sample),
    .in1       (in1),
    .in2       (in2),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got out %h with nothing expected (cycle %0d)", out, cyc);
      end else begin
        check("out_value", out, exp_q.pop_front());
        check("out_valid_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
    if (overrun) begin
      if (ovr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_overrun: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        check("overrun_cycle", 64'(cyc), 64'(ovr_q.pop_front()));
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [C*B-1:0] v1, input logic [C*B-1:0] v2,
                       input logic [C*B-1:0] va, input logic [C*B-1:0] vb,
                       input logic [2*C-1:0] vm, input logic [C*B-1:0] expv,
                       input logic push, output int c0);
    in1 = v1; in2 = v2; a = va; b = vb; mode = vm;
    sample = 1'b1;
    c0 = cyc;
    if (push) begin
      exp_q.push_back(expv);
      exp_cyc_q.push_back(c0 + LAT);
    end
    @(posedge clk);
    #1;
    sample = 1'b0;
    check("busy_cycle1", 64'(busy), 64'd1);
  endtask

  initial begin
    int c0, c1, c2, c3;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_out", out, 64'h0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);

    // One channel per mode, all inputs 0.5
    issue({4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}},
          8'b11_10_01_00, 64'h0000_4000_2000_3000, 1'b1, c0);
    goto(c0 + LAT - 1);
    check("busy_last_wr", 64'(busy), 64'd1);
    goto(c0 + LAT);
    check("busy_after_frame", 64'(busy), 64'd0);
    goto(c0 + LAT + 3);

    // AM basic, AM saturation, AM negative, ring (-1)*(-1)
    issue({16'h8000, 16'h4000, 16'h7FFF, 16'h4000},
          {16'h8000, 16'hC000, 16'h8000, 16'h4000},
          {16'h0000, 16'h4000, 16'h8000, 16'h4000},
          {16'h0000, 16'h0000, 16'h7FFF, 16'h4000},
          8'b01_00_00_00, 64'h7FFF_F000_7FFE_3000, 1'b1, c0);
    goto(c0 + LAT + 2);

    // Snapshot and overrun, then a back-to-back frame at the earliest legal cycle
    issue({16'h2000, 16'h7FFF, 16'h1234, 16'h4000},
          {16'hE000, 16'h2000, 16'h0000, 16'h2000},
          {16'h0000, 16'h2000, 16'h0000, 16'h0000},
          {16'h0000, 16'h1000, 16'h0000, 16'h0000},
          8'b01_00_10_01, 64'hF800_17FF_1234_1000, 1'b1, c0);
    goto(c0 + 2);
    in1 = {4{16'h7FFF}}; in2 = {4{16'h7FFF}}; a = {4{16'h7FFF}}; b = {4{16'h7FFF}};
    mode = 8'hFF;
    goto(c0 + 5);
    sample = 1'b1;
    ovr_q.push_back(c0 + 6);
    goto(c0 + 6);
    sample = 1'b0;
    goto(c0 + LAT);
    check("busy_before_b2b", 64'(busy), 64'd0);
    issue({16'h0001, 16'h8000, 16'h7FFF, 16'hABCD}, '0, '0, '0,
          8'b10_10_10_10, 64'h0001_8000_7FFF_ABCD, 1'b1, c1);
    goto(c1 + LAT + 2);

    // Reset mid-frame aborts with no out_valid and clears out
    issue({4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}},
          8'b11_10_01_00, '0, 1'b0, c2);
    goto(c2 + 4);
    reset = 1'b1;
    goto(c2 + 5);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out", out, 64'h0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    goto(c2 + LAT + 4);

    // Reset and sample together: sample is dropped
    reset = 1'b1;
    sample = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample = 1'b0;
    check("reset_wins_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("reset_wins_busy2", 64'(busy), 64'd0);

    // Floor truncation, negative ring product, AM add saturation, mute
    issue({16'h1111, 16'h4000, 16'h7FFF, 16'h4000},
          {16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF},
          {16'h0000, 16'h7FFF, 16'h0000, 16'h0000},
          {16'h0000, 16'h7FFF, 16'h0000, 16'h0000},
          8'b11_00_01_01, 64'h0000_3FFF_8001_FFFF, 1'b1, c3);

    for (int i = 0; i < 200 && (exp_q.size() != 0 || ovr_q.size() != 0); i++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0 || ovr_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d outputs and %0d overruns still pending, expected 0",
               exp_q.size(), ovr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modulator_bank.md
# modulator_bank

Multi-channel, time-shared amplitude/ring modulator: per channel computes out = ((a·in2)+b)·in1 (AM) or a per-channel alternative mode, using one registered signed multiplier sequenced by an FSM. It sits in the audio core path after the oscillators, triggered once per audio frame by a sample strobe, and presents all channel results simultaneously with a valid pulse. It generalises the single-channel modulator in channel count, width and mode, and adds saturation, input snapshotting and overrun detection.

## Interface
- BITSIZE, 16, sample width; all samples signed Q1.(BITSIZE-1)
- CHANNELS, 4, number of channels (≥1)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sample  in  1  one-cycle start strobe (one per audio frame, e.g. lrclk rising edge synchronised)
- in1  in  CHANNELS*BITSIZE  carrier per channel, channel k at [k*BITSIZE +: BITSIZE]
- in2  in  CHANNELS*BITSIZE  modulating signal per channel
- a  in  CHANNELS*BITSIZE  modulation depth per channel
- b  in  CHANNELS*BITSIZE  offset per channel
- mode  in  2*CHANNELS  per channel: 00 AM, 01 ring (in2·in1), 10 bypass (in1), 11 mute (0)
- out  out  CHANNELS*BITSIZE  results, held until next update
- out_valid  out  1  one-cycle pulse when out updates
- busy  out  1  high while computing
- overrun  out  1  one-cycle pulse when sample arrives while busy

## Operation
- States: IDLE, M1, M2, WR; channel index ch counts 0..CHANNELS-1.
- IDLE + sample: snapshot in1/in2/a/b/mode for all channels; ch←0; → M1.
- M1: drive multiplier with (a[ch], in2[ch]) → M2.
- M2: p1 = multiplier result; drive (sat(p1+b[ch]), in1[ch]) for AM, (in2[ch], in1[ch]) for ring; bypass/mute operands don't care → WR.
- WR: result = p2 (AM/ring), in1[ch] (bypass), 0 (mute) into staging[ch]; if ch = CHANNELS-1 copy staging to out, pulse out_valid, → IDLE; else ch+1, → M1.
- Multiply: full 2·BITSIZE signed product, arithmetic shift right BITSIZE-1 (truncate toward −∞), saturate to [−2^(BITSIZE-1), 2^(BITSIZE-1)−1]; only (−1)·(−1) saturates.
- Add: BITSIZE+1-bit signed sum, saturated to BITSIZE.
- Mode affects datapath only; cycle count is constant.
- sample while busy: ignored, snapshot untouched, overrun pulses next cycle.
- Input changes after acceptance have no effect on the running frame.

## Timing
- sample accepted at cycle 0 → ch k M1 at 1+3k, M2 at 2+3k, WR at 3+3k.
- out and out_valid visible at cycle 3·CHANNELS+1; busy high cycles 1..3·CHANNELS.
- At cycle 3·CHANNELS+1 FSM is IDLE: a sample in that cycle is accepted (no overrun).
- Minimum sample period 3·CHANNELS+1 cycles.
- Multiplier latency exactly 1 cycle (operands at t, registered result at t+1).
- Reset: state IDLE, ch 0, out all 0, staging 0, out_valid 0, busy 0, overrun 0; reset mid-frame aborts with no out_valid and out forced to 0.
- reset and sample same cycle: reset wins, sample dropped.

## Structure
- Shared package modulator_pkg: mode encodings (MODE_AM, MODE_RING, MODE_BYPASS, MODE_MUTE), FSM state encoding, BITSIZE default.
- Sub-module modulator_mac: registered signed multiplier with shift and saturation, parameter BITSIZE, ports clk, reset, op_a, op_b, prod.
- Saturating adder stays inline in modulator_bank.

## Test plan
- CHANNELS=1, AM, a=0x4000, in2=0x4000, b=0x4000, in1=0x4000 → out=0x3000, out_valid at cycle 4.
- AM saturation: a=0x8000, in2=0x8000, b=0x7FFF, in1=0x7FFF → out=0x7FFE; negative: a=0x4000, in2=0xC000, b=0, in1=0x4000 → 0xF000.
- CHANNELS=4, modes 00/01/10/11, all inputs 0x4000 → out = {0x0000, 0x4000, 0x2000, 0x3000} (ch3..ch0); single out_valid at cycle 13.
- sample at cycle 5 of a frame → overrun pulse at 6, results unchanged; back-to-back sample exactly at 3·CHANNELS+1 → accepted, no overrun.
- Inputs changed at cycle 2 after acceptance → out reflects snapshot values.
- reset asserted mid-frame (cycle 4, CHANNELS=4) → out=0, no out_valid, busy low next cycle; next sample completes normally.
